responder_sequencer: RTL and testbench

Multiple-response resolver placed directly downstream of the tag register bank in the content-addressable parallel processor. On a start command it snapshots the 100-bit tag vector and presents the index of each set tag (each responder) one at a time, lowest index first, over a valid/ready handshake. After the last responder is accepted it pulses `done`. The sequencer's controller uses it to step through responders for read-out or write-back.

---
 rtl/responder_sequencer.sv | 112 +++++++++++
 tb/tb_responder_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/responder_sequencer.sv
// rtl/responder_sequencer.sv - multiple-response resolver, emits set tag indices lowest first
// Optional responder counter enabled by defining RESP_SEQ_COUNT_EN.
module responder_sequencer #(
    parameter int N     = 100,
    parameter int IDX_W = 7,
    parameter int CNT_W = 7
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N-1:0]     tags,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             resp_valid,
    output logic [IDX_W-1:0] resp_idx,
    input  logic             resp_ready,
    output logic             done,
    output logic [CNT_W-1:0] resp_count
);

    typedef enum logic [1:0] {IDLE, PRESENT, FINISH} state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     pend_q, pend_d, pend_clr, enc_in;
    logic [IDX_W-1:0] idx_q, idx_d, enc_idx;
    logic             accept, clr_cnt;

    // One shared encoder: fresh tags while idle, the post-accept pending set otherwise.
    always_comb begin
        pend_clr = pend_q & ~({{(N-1){1'b0}}, 1'b1} << idx_q);
        enc_in   = (state_q == IDLE) ? tags : pend_clr;
        enc_idx  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (enc_in[i]) enc_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        idx_d   = idx_q;
        accept  = 1'b0;
        clr_cnt = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    pend_d  = tags;
                    idx_d   = enc_idx;
                    clr_cnt = 1'b1;
                    state_d = (|tags) ? PRESENT : FINISH;
                end
            end
            PRESENT: begin
                if (resp_ready) begin
                    accept = 1'b1;
                    pend_d = pend_clr;
                    if (|pend_clr) idx_d = enc_idx;
                    else           state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort wins over start and accept; count and index are left untouched.
        if (abort) begin
            state_d = IDLE;
            pend_d  = '0;
            idx_d   = idx_q;
            accept  = 1'b0;
            clr_cnt = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            pend_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            idx_q   <= idx_d;
        end
    end

`ifdef RESP_SEQ_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_cnt)     cnt_d = '0;
        else if (accept) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign resp_count = cnt_q;
`else
    logic unused_cnt;
    assign unused_cnt = accept ^ clr_cnt;
    assign resp_count = '0;
`endif

    assign busy       = (state_q != IDLE);
    assign resp_valid = (state_q == PRESENT);
    assign done       = (state_q == FINISH);
    assign resp_idx   = idx_q;

endmodule

// File: tb/tb_responder_sequencer.sv
// tb/tb_responder_sequencer.sv - self-checking bench for responder_sequencer
// Queue-based reference model plus directed literal checks.
module tb_responder_sequencer;

    localparam int N     = 100;
    localparam int IDX_W = 7;
    localparam int CNT_W = 7;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic [N-1:0]     tags = '0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             resp_ready = 1'b0;
    logic             busy, resp_valid, done;
    logic [IDX_W-1:0] resp_idx;
    logic [CNT_W-1:0] resp_count;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    responder_sequencer #(.N(N), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST_N(RST_N), .tags(tags), .start(start), .abort(abort),
        .busy(busy), .resp_valid(resp_valid), .resp_idx(resp_idx),
        .resp_ready(resp_ready), .done(done), .resp_count(resp_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int exp_cnt(input int n);
`ifdef RESP_SEQ_COUNT_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    function automatic logic [N-1:0] mk(input int a, input int b = -1, input int c = -1);
        logic [N-1:0] v;
        v = '0;
        if (a >= 0) v[a] = 1'b1;
        if (b >= 0) v[b] = 1'b1;
        if (c >= 0) v[c] = 1'b1;
        return v;
    endfunction

    // Reference model: a pass is just the ascending list of set tag indices.
    int mq[$];
    bit m_pres = 1'b0;
    bit m_fin = 1'b0;
    int m_cnt = 0;
    int m_idx = 0;

    task automatic model_step();
        if (!RST_N) begin
            mq.delete();
            m_pres = 1'b0; m_fin = 1'b0; m_cnt = 0; m_idx = 0;
        end else if (abort) begin
            mq.delete();
            m_pres = 1'b0; m_fin = 1'b0;
        end else if (m_fin) begin
            m_fin = 1'b0;
        end else if (m_pres) begin
            if (resp_ready) begin
                void'(mq.pop_front());
                m_cnt++;
                if (mq.size() == 0) begin
                    m_pres = 1'b0; m_fin = 1'b1;
                end else begin
                    m_idx = mq[0];
                end
            end
        end else if (start) begin
            mq.delete();
            for (int i = 0; i < N; i++) if (tags[i]) mq.push_back(i);
            m_cnt = 0;
            if (mq.size() > 0) begin
                m_pres = 1'b1; m_idx = mq[0];
            end else begin
                m_fin = 1'b1;
            end
        end
    endtask

    always @(posedge CLK) model_step();

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("m_busy", int'(busy), int'(m_pres | m_fin));
            chk("m_valid", int'(resp_valid), int'(m_pres));
            chk("m_done", int'(done), int'(m_fin));
            chk("m_count", int'(resp_count), exp_cnt(m_cnt));
            if (m_pres) chk("m_idx", int'(resp_idx), m_idx);
        end
    end

    initial begin
        repeat (2) @(negedge CLK);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(resp_valid), 0);
        chk("rst_idx", int'(resp_idx), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_count", int'(resp_count), 0);
        chk_en = 1'b1;
        RST_N = 1'b1;
        @(negedge CLK);

        // {3,17,99} streamed back-to-back
        tags = mk(3, 17, 99); resp_ready = 1'b1; start = 1'b1;
        @(negedge CLK); start = 1'b0; tags = '0;
        chk("t1_idx0", int'(resp_idx), 3);
        chk("t1_valid", int'(resp_valid), 1);
        chk("t1_busy", int'(busy), 1);
        @(negedge CLK); chk("t1_idx1", int'(resp_idx), 17);
        @(negedge CLK); chk("t1_idx2", int'(resp_idx), 99);
        @(negedge CLK);
        chk("t1_done", int'(done), 1);
        chk("t1_valid_end", int'(resp_valid), 0);
        chk("t1_count", int'(resp_count), exp_cnt(3));
        @(negedge CLK); chk("t1_idle", int'(busy), 0);
        resp_ready = 1'b0;

        // empty tag vector
        tags = '0; start = 1'b1;
        @(negedge CLK); start = 1'b0;
        chk("t2_done", int'(done), 1);
        chk("t2_valid", int'(resp_valid), 0);
        chk("t2_count", int'(resp_count), 0);
        @(negedge CLK); chk("t2_idle", int'(busy), 0);

        // {0,50} with back-pressure
        tags = mk(0, 50); start = 1'b1;
        @(negedge CLK); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t3_hold_idx", int'(resp_idx), 0);
            chk("t3_hold_valid", int'(resp_valid), 1);
            if (i < 3) @(negedge CLK);
        end
        resp_ready = 1'b1;
        @(negedge CLK); chk("t3_idx50", int'(resp_idx), 50);
        @(negedge CLK);
        chk("t3_done", int'(done), 1);
        chk("t3_count", int'(resp_count), exp_cnt(2));
        @(negedge CLK); resp_ready = 1'b0;

        // abort coincident with the first accept
        tags = mk(5, 6, 7); resp_ready = 1'b1; start = 1'b1;
        @(negedge CLK); start = 1'b0;
        chk("t4_idx5", int'(resp_idx), 5);
        abort = 1'b1;
        @(negedge CLK); abort = 1'b0;
        chk("t4_busy", int'(busy), 0);
        chk("t4_valid", int'(resp_valid), 0);
        chk("t4_done", int'(done), 0);
        chk("t4_count", int'(resp_count), 0);
        @(negedge CLK); chk("t4_nodone", int'(done), 0);
        tags = mk(9); start = 1'b1;
        @(negedge CLK); start = 1'b0;
        chk("t4_idx9", int'(resp_idx), 9);
        @(negedge CLK);
        chk("t4_done9", int'(done), 1);
        chk("t4_count9", int'(resp_count), exp_cnt(1));
        @(negedge CLK); chk("t4_idle", int'(busy), 0);
        resp_ready = 1'b0;

        // start while busy and tag changes after capture are ignored
        tags = mk(1, 2); start = 1'b1;
        @(negedge CLK); tags = mk(40);
        chk("t5_idx1", int'(resp_idx), 1);
        @(negedge CLK); start = 1'b0; tags = mk(60);
        chk("t5_idx1_hold", int'(resp_idx), 1);
        resp_ready = 1'b1;
        @(negedge CLK); chk("t5_idx2", int'(resp_idx), 2);
        @(negedge CLK);
        chk("t5_done", int'(done), 1);
        chk("t5_count", int'(resp_count), exp_cnt(2));
        @(negedge CLK); chk("t5_idle", int'(busy), 0);
        resp_ready = 1'b0;

        // reset in the middle of a pass
        tags = mk(3, 4); start = 1'b1;
        @(negedge CLK); start = 1'b0;
        chk("t6_valid", int'(resp_valid), 1);
        RST_N = 1'b0;
        @(negedge CLK); RST_N = 1'b1;
        chk("t6_busy", int'(busy), 0);
        chk("t6_valid0", int'(resp_valid), 0);
        chk("t6_idx", int'(resp_idx), 0);
        chk("t6_done", int'(done), 0);
        chk("t6_count", int'(resp_count), 0);
        @(negedge CLK); chk("t6_nodone", int'(done), 0);
        @(negedge CLK); chk("t6_nodone2", int'(done), 0);

        repeat (2) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
